uart_echo_bridge: RTL and testbench

// Parametrised echo engine between a UART receiver and a UART transmitter.

---
 rtl/uart_echo_bridge.sv | 128 ++++++++++++
 tb/tb_uart_echo_bridge.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_bridge.sv
// UART echo engine: FIFO-buffered rx words replayed to the tx with echo/CRLF/fold/discard modes.
// rx_done->tx_start is 2 clocks when idle; a full FIFO drops words (sticky overflow), a silent tx times out.
module uart_echo_bridge #(
    parameter int DATA_BITS  = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_done,
    input  logic [DATA_BITS-1:0]  rx_data,
    input  logic                  tx_done,
    input  logic [1:0]            mode,
    input  logic                  clear_flags,
    output logic                  tx_start,
    output logic [DATA_BITS-1:0]  tx_data,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  busy,
    output logic                  overflow,
    output logic                  timeout_err
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [DATA_BITS-1:0] CR_CHAR  = DATA_BITS'(8'h0D);
    localparam logic [DATA_BITS-1:0] LF_CHAR  = DATA_BITS'(8'h0A);
    localparam logic [DATA_BITS-1:0] LC_FIRST = DATA_BITS'(8'h61);
    localparam logic [DATA_BITS-1:0] LC_LAST  = DATA_BITS'(8'h7A);
    localparam logic [DATA_BITS-1:0] CASE_OFS = DATA_BITS'(8'h20);

    localparam logic [1:0] MODE_CRLF    = 2'b01;
    localparam logic [1:0] MODE_DISCARD = 2'b10;
    localparam logic [1:0] MODE_UPPER   = 2'b11;

    typedef enum logic [2:0] {IDLE, START, WAIT, LF_START, LF_WAIT} state_t;

    state_t                 state;
    logic [1:0]             cur_mode;
    logic [TW-1:0]          tmo_cnt;
    logic                   tmo_hit;
    logic [DATA_BITS-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [ADDR_WIDTH-1:0]  rd_ptr;
    logic [DATA_BITS-1:0]   head;
    logic                   push;
    logic                   pop;

    assign head    = mem[rd_ptr];
    assign pop     = (state == IDLE) && (fifo_count != '0);
    // A full FIFO still accepts a word when the head leaves in the same clock.
    assign push    = rx_done && ((fifo_count != (ADDR_WIDTH+1)'(DEPTH)) || pop);
    assign busy    = (state != IDLE);
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (rx_done && !push) overflow <= 1'b1;
            else if (clear_flags) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            cur_mode    <= 2'b00;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            if (clear_flags) timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_mode <= mode;
                        if (mode != MODE_DISCARD) begin
                            if (mode == MODE_UPPER && head >= LC_FIRST && head <= LC_LAST)
                                tx_data <= head - CASE_OFS;
                            else
                                tx_data <= head;
                            tx_start <= 1'b1;
                            state    <= START;
                        end
                    end
                end
                START, LF_START: begin
                    tmo_cnt <= '0;
                    state   <= (state == START) ? WAIT : LF_WAIT;
                end
                WAIT, LF_WAIT: begin
                    // tx_done beats a timeout landing in the same clock.
                    if (tx_done) begin
                        if (state == WAIT && cur_mode == MODE_CRLF && tx_data == CR_CHAR) begin
                            tx_data  <= LF_CHAR;
                            tx_start <= 1'b1;
                            state    <= LF_START;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_echo_bridge.sv
// Directed bench for uart_echo_bridge (depth 4, timeout 20) with a modelled transmitter.
module tb_uart_echo_bridge;
    logic       clock = 1'b0;
    logic       reset;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_done;
    logic [1:0] mode;
    logic       clear_flags;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [2:0] fifo_count;
    logic       busy;
    logic       overflow;
    logic       timeout_err;

    uart_echo_bridge #(.DATA_BITS(8), .ADDR_WIDTH(2), .TIMEOUT(20)) dut (
        .clock(clock), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
        .tx_done(tx_done), .mode(mode), .clear_flags(clear_flags),
        .tx_start(tx_start), .tx_data(tx_data), .fifo_count(fifo_count),
        .busy(busy), .overflow(overflow), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    int total = 0;
    int bad   = 0;
    logic [7:0] cap_q[$];
    int         start_q[$];
    int         starts = 0;
    logic       auto_done = 1'b1;

    // Transmitter model: records each tx_start word, answers tx_done 10 clocks later.
    initial begin
        int  dly;
        logic pending;
        tx_done = 1'b0;
        pending = 1'b0;
        dly     = 0;
        forever begin
            @(negedge clock);
            tx_done = 1'b0;
            if (reset) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    if (dly == 0) begin
                        tx_done = 1'b1;
                        pending = 1'b0;
                    end else begin
                        dly--;
                    end
                end
                if (tx_start) begin
                    cap_q.push_back(tx_data);
                    start_q.push_back(cycle);
                    starts++;
                    pending = auto_done;
                    dly     = 9;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] capv(input int i);
        if (i < cap_q.size()) return {24'h0, cap_q[i]};
        return 32'hDEAD;
    endfunction

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic wait_quiet(input int bound);
        int n = 0;
        while ((busy || fifo_count != 0) && n < bound) begin
            tick();
            n++;
        end
        chk("quiet_bound", {31'h0, n < bound}, 32'h1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int rx_cyc;
        int s0;
        int n;
        int d;
        reset       = 1'b1;
        rx_done     = 1'b0;
        rx_data     = 8'h00;
        mode        = 2'b00;
        clear_flags = 1'b0;
        tick();
        chk("rst_tx_start", {31'h0, tx_start}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("rst_count", {29'h0, fifo_count}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_flags", {30'h0, overflow, timeout_err}, 32'h0);
        reset = 1'b0;
        tick();

        // Plain echo with latency check.
        cap_q.delete();
        start_q.delete();
        rx_cyc = cycle;
        send(8'h41);
        chk("lat_count1", {29'h0, fifo_count}, 32'h1);
        send(8'h42);
        send(8'h43);
        wait_quiet(200);
        chk("echo_n", cap_q.size(), 32'd3);
        chk("echo_0", capv(0), 32'h41);
        chk("echo_1", capv(1), 32'h42);
        chk("echo_2", capv(2), 32'h43);
        chk("echo_latency", (start_q.size() > 0) ? start_q[0] - rx_cyc : -1, 32'd2);

        // CR expands to CR LF; a bare LF passes through once.
        mode = 2'b01;
        cap_q.delete();
        send(8'h0D);
        send(8'h31);
        wait_quiet(200);
        chk("crlf_n", cap_q.size(), 32'd3);
        chk("crlf_0", capv(0), 32'h0D);
        chk("crlf_1", capv(1), 32'h0A);
        chk("crlf_2", capv(2), 32'h31);
        cap_q.delete();
        send(8'h0A);
        wait_quiet(200);
        chk("lf_n", cap_q.size(), 32'd1);
        chk("lf_0", capv(0), 32'h0A);

        // Upper-case fold, including both edges of the a..z range.
        mode = 2'b11;
        cap_q.delete();
        send(8'h61);
        send(8'h7A);
        send(8'h5B);
        send(8'h60);
        send(8'h7B);
        wait_quiet(400);
        chk("fold_n", cap_q.size(), 32'd5);
        chk("fold_0", capv(0), 32'h41);
        chk("fold_1", capv(1), 32'h5A);
        chk("fold_2", capv(2), 32'h5B);
        chk("fold_3", capv(3), 32'h60);
        chk("fold_4", capv(4), 32'h7B);

        // Discard: queue three behind an in-flight echo, then drain one per clock.
        mode = 2'b00;
        cap_q.delete();
        send(8'h58);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        mode = 2'b10;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("disc_idle", {31'h0, busy}, 32'h0);
        s0 = starts;
        chk("disc_c3", {29'h0, fifo_count}, 32'd3);
        tick();
        chk("disc_c2", {29'h0, fifo_count}, 32'd2);
        tick();
        chk("disc_c1", {29'h0, fifo_count}, 32'd1);
        tick();
        chk("disc_c0", {29'h0, fifo_count}, 32'd0);
        tick();
        chk("disc_no_start", starts - s0, 32'd0);
        chk("disc_inflight", capv(0), 32'h58);

        // Overflow with the transmitter stalled.
        do_reset();
        mode      = 2'b00;
        auto_done = 1'b0;
        cap_q.delete();
        start_q.delete();
        send(8'hA0);
        send(8'hA1);
        send(8'hA2);
        send(8'hA3);
        send(8'hA4);
        chk("ovf_full", {29'h0, fifo_count}, 32'd4);
        chk("ovf_not_yet", {31'h0, overflow}, 32'h0);
        send(8'hA5);
        chk("ovf_count", {29'h0, fifo_count}, 32'd4);
        chk("ovf_set", {31'h0, overflow}, 32'h1);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("ovf_clear", {31'h0, overflow}, 32'h0);

        // Stalled word times out; then push and pop collide at a full FIFO.
        n = 0;
        while (!timeout_err && n < 60) begin
            tick();
            n++;
        end
        chk("tmo_set", {31'h0, timeout_err}, 32'h1);
        d = (start_q.size() > 0) ? cycle - start_q[0] : -1;
        chk("tmo_latency", {31'h0, (d >= 20 && d <= 21)}, 32'h1);
        chk("tmo_idle", {31'h0, busy}, 32'h0);
        chk("tmo_count", {29'h0, fifo_count}, 32'd4);
        send(8'hA6);
        chk("pp_count", {29'h0, fifo_count}, 32'd4);
        chk("pp_no_ovf", {31'h0, overflow}, 32'h0);
        chk("pp_head", {24'h0, tx_data}, 32'hA1);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("tmo_clear", {31'h0, timeout_err}, 32'h0);

        // Reset in WAIT with three words queued.
        do_reset();
        send(8'hB1);
        send(8'hB2);
        send(8'hB3);
        send(8'hB4);
        tick();
        chk("prerst_count", {29'h0, fifo_count}, 32'd3);
        chk("prerst_busy", {31'h0, busy}, 32'h1);
        chk("prerst_data", {24'h0, tx_data}, 32'hB1);
        reset = 1'b1;
        #1;
        chk("mrst_tx_start", {31'h0, tx_start}, 32'h0);
        chk("mrst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("mrst_count", {29'h0, fifo_count}, 32'h0);
        chk("mrst_busy", {31'h0, busy}, 32'h0);
        chk("mrst_flags", {30'h0, overflow, timeout_err}, 32'h0);
        tick();
        reset     = 1'b0;
        auto_done = 1'b1;
        s0 = starts;
        repeat (5) tick();
        chk("resume_no_stale", starts - s0, 32'd0);
        cap_q.delete();
        send(8'h55);
        wait_quiet(200);
        chk("resume_n", cap_q.size(), 32'd1);
        chk("resume_0", capv(0), 32'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
